// File: rtl/uart_bus_loader_pkg.sv
// Shared types and constants for the UART-driven RAM loader.
// Holds the loader/receiver state enums, protocol bytes and the baud divisor helper.
package uart_bus_loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    ADDR,
    DATA,
    REQ,
    WR_ADDR,
    WR_DATA,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;

  // Clocks per UART bit, truncated toward zero.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bus_loader_if.sv
// Handshake and drive signals between the loader (master) and the computer's main bus (slave).
interface uart_bus_loader_if;
  logic       bus_clk_rise;
  logic       bus_gnt;
  logic       bus_req;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       mi;
  logic       ri;

  modport master (
    input  bus_clk_rise, bus_gnt,
    output bus_req, bus_out, bus_oe, mi, ri
  );

  modport slave (
    output bus_clk_rise, bus_gnt,
    input  bus_req, bus_out, bus_oe, mi, ri
  );
endinterface

// File: rtl/uart_bus_loader_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-clk valid / framing-error pulses.
module uart_rx_byte
  import uart_bus_loader_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // A glitch that has gone high again by mid-bit is not a start bit.
          if (!sync2_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_bus_loader.sv
// Receives "SYNC addr data" commands over UART and performs MI/RI write cycles on the main bus.
// Optional ACK/NAK transmitter on usb_tx is enabled by defining UART_BUS_LOADER_ACK_EN.
module uart_bus_loader
  import uart_bus_loader_pkg::*;
#(
  parameter int         CLK_FREQ  = 100000000,
  parameter int         BAUD      = 115200,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_rx,
  uart_bus_loader_if.master bus,
`ifdef UART_BUS_LOADER_ACK_EN
  output logic       usb_tx,
`endif
  output logic       load_done,
  output logic [7:0] write_count,
  output logic       err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (usb_rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (rx_frame_err)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              armed_q, armed_d;
  logic              bus_req_q, bus_req_d;
  logic [7:0]        bus_out_q, bus_out_d;
  logic              bus_oe_q, bus_oe_d;
  logic              mi_q, mi_d;
  logic              ri_q, ri_d;
  logic              load_done_q, load_done_d;
  logic [7:0]        write_count_q, write_count_d;
  logic              err_q, err_d;
  logic              overrun;
  logic              gnt_lost;
  logic              in_wr;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    overrun  = 1'b0;
    gnt_lost = 1'b0;
    case (state_q)
      SYNC: if (rx_valid && rx_data == SYNC_BYTE) state_d = ADDR;
      ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_W-1:0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = REQ;
        end
      end
      REQ: begin
        overrun = rx_valid;
        if (bus.bus_gnt) state_d = WR_ADDR;
      end
      WR_ADDR: begin
        overrun = rx_valid;
        if (!bus.bus_gnt) begin
          gnt_lost = 1'b1;
          state_d  = SYNC;
        end else if (bus.bus_clk_rise && armed_q) begin
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        overrun = rx_valid;
        if (!bus.bus_gnt) begin
          gnt_lost = 1'b1;
          state_d  = SYNC;
        end else if (bus.bus_clk_rise && armed_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        overrun = rx_valid;
        state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase

    // A bad frame while collecting a command abandons it; a write already under way carries on.
    if (rx_frame_err && (state_q == SYNC || state_q == ADDR || state_q == DATA)) begin
      state_d = SYNC;
    end

    in_wr = (state_q == WR_ADDR) || (state_q == WR_DATA);

    // The first clk in each write state ignores bus_clk_rise so the registered strobe is
    // already up before the edge that is allowed to complete the phase.
    armed_d = in_wr && (state_d == state_q);

    bus_req_d     = (state_q == REQ) || (in_wr && !gnt_lost);
    bus_oe_d      = in_wr && bus.bus_gnt;
    mi_d          = (state_q == WR_ADDR) && bus.bus_gnt;
    ri_d          = (state_q == WR_DATA) && bus.bus_gnt;
    bus_out_d     = mi_d ? 8'(addr_q) : (ri_d ? data_q : 8'h00);
    load_done_d   = (state_q == DONE);
    write_count_d = (state_q == DONE) ? write_count_q + 8'd1 : write_count_q;
    err_d         = err_q | rx_frame_err | overrun | gnt_lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      addr_q        <= '0;
      data_q        <= 8'h00;
      armed_q       <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_out_q     <= 8'h00;
      bus_oe_q      <= 1'b0;
      mi_q          <= 1'b0;
      ri_q          <= 1'b0;
      load_done_q   <= 1'b0;
      write_count_q <= 8'h00;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      armed_q       <= armed_d;
      bus_req_q     <= bus_req_d;
      bus_out_q     <= bus_out_d;
      bus_oe_q      <= bus_oe_d;
      mi_q          <= mi_d;
      ri_q          <= ri_d;
      load_done_q   <= load_done_d;
      write_count_q <= write_count_d;
      err_q         <= err_d;
    end
  end

  assign bus.bus_req  = bus_req_q;
  assign bus.bus_out  = bus_out_q;
  assign bus.bus_oe   = bus_oe_q;
  assign bus.mi       = mi_q;
  assign bus.ri       = ri_q;
  assign load_done    = load_done_q;
  assign write_count  = write_count_q;
  assign err          = err_q;

`ifdef UART_BUS_LOADER_ACK_EN
  localparam int TX_CNT_W = $clog2(DIV + 1);
  localparam logic [TX_CNT_W-1:0] TX_FULL_M1 = TX_CNT_W'(DIV - 1);

  logic                tx_busy_q, tx_busy_d;
  logic [9:0]          tx_shift_q, tx_shift_d;
  logic [3:0]          tx_bits_q, tx_bits_d;
  logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic                pend_valid_q, pend_valid_d;
  logic [7:0]          pend_byte_q, pend_byte_d;
  logic                usb_tx_q, usb_tx_d;
  logic                tx_req;
  logic [7:0]          tx_byte;
  logic [7:0]          launch_byte;

  always_comb begin
    tx_req      = 1'b0;
    tx_byte     = ACK_BYTE;
    launch_byte = ACK_BYTE;
    if (rx_frame_err || overrun || gnt_lost) begin
      tx_req  = 1'b1;
      tx_byte = NAK_BYTE;
    end else if (state_q == DONE) begin
      tx_req  = 1'b1;
      tx_byte = ACK_BYTE;
    end

    tx_busy_d    = tx_busy_q;
    tx_shift_d   = tx_shift_q;
    tx_bits_d    = tx_bits_q;
    tx_cnt_d     = tx_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    usb_tx_d     = usb_tx_q;

    if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        if (tx_bits_q == 4'd0) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bits_d  = tx_bits_q - 4'd1;
          tx_cnt_d   = TX_FULL_M1;
          usb_tx_d   = tx_shift_q[1];
        end
      end else begin
        tx_cnt_d = tx_cnt_q - 1'b1;
      end
    end

    // The pending slot drains first; a request arriving with both busy and slot full is lost.
    if (!tx_busy_q && (pend_valid_q || tx_req)) begin
      launch_byte = pend_valid_q ? pend_byte_q : tx_byte;
      tx_shift_d  = {1'b1, launch_byte, 1'b0};
      tx_bits_d   = 4'd9;
      tx_cnt_d    = TX_FULL_M1;
      tx_busy_d   = 1'b1;
      usb_tx_d    = 1'b0;
      if (pend_valid_q) begin
        pend_valid_d = tx_req;
        pend_byte_d  = tx_req ? tx_byte : pend_byte_q;
      end
    end else if (tx_req && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_byte_d  = tx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q    <= 1'b0;
      tx_shift_q   <= 10'h3FF;
      tx_bits_q    <= 4'd0;
      tx_cnt_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= 8'h00;
      usb_tx_q     <= 1'b1;
    end else begin
      tx_busy_q    <= tx_busy_d;
      tx_shift_q   <= tx_shift_d;
      tx_bits_q    <= tx_bits_d;
      tx_cnt_q     <= tx_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      usb_tx_q     <= usb_tx_d;
    end
  end

  assign usb_tx = usb_tx_q;
`endif

endmodule

// File: tb/tb_uart_bus_loader.sv
// Scoreboard bench for uart_bus_loader: directed UART commands, monitor checks each completed bus write.
module tb_uart_bus_loader;

  localparam int DIV     = 16;
  localparam int BUS_PER = 200;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_rx = 1'b1;
  logic       load_done;
  logic [7:0] write_count;
  logic       err;
`ifdef UART_BUS_LOADER_ACK_EN
  logic       usb_tx;
`endif

  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  exp_t exp_q[$];
  logic [7:0] mi_addr;
  logic [7:0] ri_data;

  uart_bus_loader_if bus();

  uart_bus_loader #(
    .CLK_FREQ  (1000000),
    .BAUD      (62500),
    .ADDR_W    (4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .usb_rx      (usb_rx),
    .bus         (bus),
`ifdef UART_BUS_LOADER_ACK_EN
    .usb_tx      (usb_tx),
`endif
    .load_done   (load_done),
    .write_count (write_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    usb_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      usb_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    usb_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (DIV) @(negedge clk);
    usb_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_seen < target) begin
      errors++;
      $display("[TB] FAIL write_timeout: got %0d writes, expected %0d", done_seen, target);
    end
  endtask

  // Grant the bus just after a bus_clk rise so the next rise is a full period away.
  task automatic grant_after_rise();
    int n = 0;
    while (!bus.bus_clk_rise && n < 1000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    bus.bus_gnt = 1'b1;
  endtask

  initial begin
    bus.bus_clk_rise = 1'b0;
    forever begin
      repeat (BUS_PER - 1) @(negedge clk);
      bus.bus_clk_rise = 1'b1;
      @(negedge clk);
      bus.bus_clk_rise = 1'b0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mi_addr = 'x;
        ri_data = 'x;
      end else begin
        if (bus.mi && bus.bus_oe) mi_addr = bus.bus_out;
        if (bus.ri && bus.bus_oe) ri_data = bus.bus_out;
        if (load_done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got addr 0x%02h data 0x%02h, expected none", mi_addr, ri_data);
          end else begin
            e = exp_q.pop_front();
            check_output("wr_addr", mi_addr, e.addr);
            check_output("wr_data", ri_data, e.data);
            check_output("wr_count", write_count, e.count);
          end
          mi_addr = 'x;
          ri_data = 'x;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic oe_seen;
    bus.bus_gnt = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_bit("rst_bus_req", bus.bus_req, 1'b0);
    check_bit("rst_bus_oe", bus.bus_oe, 1'b0);
    check_bit("rst_mi", bus.mi, 1'b0);
    check_bit("rst_ri", bus.ri, 1'b0);
    check_output("rst_bus_out", bus.bus_out, 8'h00);
    check_bit("rst_load_done", load_done, 1'b0);
    check_output("rst_write_count", write_count, 8'h00);
    check_bit("rst_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] basic write A5 03 2C");
    exp_q.push_back('{addr: 8'h03, data: 8'h2C, count: 8'd1});
    apply_stimulus(8'hA5, 8'h03, 8'h2C);
    wait_done(1);
    check_bit("err_after_basic", err, 1'b0);

    $display("[TB] leading junk and wide address: 11 A5 1F 80");
    exp_q.push_back('{addr: 8'h0F, data: 8'h80, count: 8'd2});
    send_byte(8'h11, 1'b0);
    apply_stimulus(8'hA5, 8'h1F, 8'h80);
    wait_done(2);

    $display("[TB] command without grant");
    bus.bus_gnt = 1'b0;
    exp_q.push_back('{addr: 8'h0A, data: 8'h5B, count: 8'd3});
    apply_stimulus(8'hA5, 8'h0A, 8'h5B);
    oe_seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.bus_oe) oe_seen = 1'b1;
    end
    check_bit("oe_while_no_gnt", oe_seen, 1'b0);
    check_bit("req_while_no_gnt", bus.bus_req, 1'b1);
    check_output("writes_while_no_gnt", 8'(done_seen), 8'd2);
    bus.bus_gnt = 1'b1;
    wait_done(3);

    $display("[TB] grant loss during RI phase");
    bus.bus_gnt = 1'b0;
    apply_stimulus(8'hA5, 8'h06, 8'h99);
    grant_after_rise();
    n = 0;
    while (!bus.ri && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_bit("ri_reached", bus.ri, 1'b1);
    check_bit("err_before_gnt_loss", err, 1'b0);
    bus.bus_gnt = 1'b0;
    @(negedge clk);
    check_bit("oe_after_gnt_loss", bus.bus_oe, 1'b0);
    check_bit("ri_after_gnt_loss", bus.ri, 1'b0);
    check_bit("err_after_gnt_loss", err, 1'b1);
    repeat (400) @(negedge clk);
    check_output("count_after_gnt_loss", write_count, 8'd3);
    bus.bus_gnt = 1'b1;

    $display("[TB] reset during MI phase");
    bus.bus_gnt = 1'b0;
    apply_stimulus(8'hA5, 8'h0C, 8'h33);
    grant_after_rise();
    repeat (20) @(negedge clk);
    check_bit("mi_in_wr_addr", bus.mi, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_oe", bus.bus_oe, 1'b0);
    check_bit("async_rst_mi", bus.mi, 1'b0);
    check_bit("async_rst_req", bus.bus_req, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("count_after_reset", write_count, 8'd0);
    check_bit("err_after_reset", err, 1'b0);
    exp_q.push_back('{addr: 8'h00, data: 8'h01, count: 8'd1});
    apply_stimulus(8'hA5, 8'h00, 8'h01);
    wait_done(4);

    $display("[TB] framing error on address byte");
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b1);
    repeat (50) @(negedge clk);
    check_bit("err_after_frame", err, 1'b1);
    check_bit("req_after_frame", bus.bus_req, 1'b0);
    exp_q.push_back('{addr: 8'h05, data: 8'h77, count: 8'd2});
    apply_stimulus(8'hA5, 8'h05, 8'h77);
    wait_done(5);

    repeat (20) @(negedge clk);
    check_output("pending_expected", 8'(exp_q.size()), 8'd0);
    check_output("final_count", write_count, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
